// File: rtl/hazard_controller_pkg.sv
// ============================================================================
// Module      : hazard_controller_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_controller_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_e;

    // Where MEM_WAIT returns once the memory miss clears
    typedef enum logic {
        RES_RUN   = 1'b0,
        RES_DRAIN = 1'b1
    } resume_e;

    localparam int unsigned DRAIN_CYCLES  = 3;
    localparam int unsigned DRAIN_CNT_W   = 2;
    localparam logic [3:0]  REG_ZERO      = 4'h0;
    localparam int unsigned STALL_CNT_W   = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

endpackage : hazard_controller_pkg

`default_nettype wire

// File: rtl/hazard_controller_if.sv
// ============================================================================
// Module      : hazard_controller_if
// Description : Pipeline-side hazard inputs and control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_controller_if;
    import hazard_controller_pkg::*;

    logic [3:0]             id_srcReg1;
    logic [3:0]             id_srcReg2;
    logic                   id_usesSrc2;
    logic [3:0]             id_ex_dstReg;
    logic                   id_ex_memRead;
    logic                   branch_taken;
    logic                   id_halt;
    logic                   mem_stall_req;

    logic                   pc_write;
    logic                   if_id_write;
    logic                   if_id_flush;
    logic                   id_ex_bubble;
    logic                   pipe_en;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_count;

    // Pipeline side: supplies hazard information, consumes control
    modport master (
        output id_srcReg1, id_srcReg2, id_usesSrc2, id_ex_dstReg,
               id_ex_memRead, branch_taken, id_halt, mem_stall_req,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_en, halted, stall_count
    );

    // Controller side
    modport slave (
        input  id_srcReg1, id_srcReg2, id_usesSrc2, id_ex_dstReg,
               id_ex_memRead, branch_taken, id_halt, mem_stall_req,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_en, halted, stall_count
    );

endinterface : hazard_controller_if

`default_nettype wire

// File: rtl/hazard_controller_load_use_detect.sv
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard comparator. R0 never hazards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_detect
    import hazard_controller_pkg::*;
(
    input  wire logic [3:0] i_src_reg1,
    input  wire logic [3:0] i_src_reg2,
    input  wire logic       i_uses_src2,
    input  wire logic [3:0] i_ex_dst_reg,
    input  wire logic       i_ex_mem_read,
    output logic            o_load_use
);

    logic w_src1_hit;
    logic w_src2_hit;

    assign w_src1_hit = (i_ex_dst_reg == i_src_reg1);
    assign w_src2_hit = i_uses_src2 && (i_ex_dst_reg == i_src_reg2);

    assign o_load_use = i_ex_mem_read && (i_ex_dst_reg != REG_ZERO)
                        && (w_src1_hit || w_src2_hit);

endmodule : load_use_detect

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// Module      : hazard_controller
// Description : Pipeline stall/flush/halt controller with memory-wait and
//               halt-drain sequencing and a saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_controller
    import hazard_controller_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_controller_if.slave hz
);

    state_e                 state_q, state_d;
    resume_e                resume_q, resume_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;
    logic                   halted_q, halted_d;

    logic                   w_load_use;
    state_e                 w_eff_state;
    logic                   w_pc_write;
    logic                   w_if_id_write;
    logic                   w_if_id_flush;
    logic                   w_id_ex_bubble;
    logic                   w_pipe_en;

    load_use_detect u_load_use_detect (
        .i_src_reg1    (hz.id_srcReg1),
        .i_src_reg2    (hz.id_srcReg2),
        .i_uses_src2   (hz.id_usesSrc2),
        .i_ex_dst_reg  (hz.id_ex_dstReg),
        .i_ex_mem_read (hz.id_ex_memRead),
        .o_load_use    (w_load_use)
    );

    // The MEM_WAIT exit cycle already acts as the state being resumed
    always_comb begin
        w_eff_state = state_q;
        if (state_q == MEM_WAIT && !hz.mem_stall_req) begin
            w_eff_state = (resume_q == RES_DRAIN) ? DRAIN : RUN;
        end
    end

    // Next-state and control-output decode
    always_comb begin
        state_d        = state_q;
        resume_d       = resume_q;
        drain_cnt_d    = drain_cnt_q;
        w_pc_write     = 1'b0;
        w_if_id_write  = 1'b0;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_pipe_en      = 1'b0;

        case (w_eff_state)
            RUN: begin
                state_d = RUN;
                if (hz.mem_stall_req) begin
                    state_d  = MEM_WAIT;
                    resume_d = RES_RUN;
                end else if (w_load_use) begin
                    // Bubble into EX; branch is retried once the load clears
                    w_id_ex_bubble = 1'b1;
                    w_pipe_en      = 1'b1;
                end else if (hz.branch_taken) begin
                    w_pc_write    = 1'b1;
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_pipe_en     = 1'b1;
                end else if (hz.id_halt) begin
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_pipe_en     = 1'b1;
                    state_d       = DRAIN;
                    drain_cnt_d   = DRAIN_CNT_W'(DRAIN_CYCLES);
                end else begin
                    w_pc_write    = 1'b1;
                    w_if_id_write = 1'b1;
                    w_pipe_en     = 1'b1;
                end
            end
            MEM_WAIT: begin
                state_d = MEM_WAIT;
            end
            DRAIN: begin
                if (hz.mem_stall_req) begin
                    state_d  = MEM_WAIT;
                    resume_d = RES_DRAIN;
                end else begin
                    w_if_id_write = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_pipe_en     = 1'b1;
                    drain_cnt_d   = drain_cnt_q - 1'b1;
                    state_d       = (drain_cnt_q == DRAIN_CNT_W'(1)) ? HALTED : DRAIN;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Registered status: halted flag and saturating stall-cycle count
    always_comb begin
        halted_d      = (state_d == HALTED);
        stall_count_d = stall_count_q;
        if (!w_pc_write && !halted_q && (stall_count_q != STALL_CNT_MAX)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            resume_q      <= RES_RUN;
            drain_cnt_q   <= '0;
            stall_count_q <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            resume_q      <= resume_d;
            drain_cnt_q   <= drain_cnt_d;
            stall_count_q <= stall_count_d;
            halted_q      <= halted_d;
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.if_id_write  = w_if_id_write;
    assign hz.if_id_flush  = w_if_id_flush;
    assign hz.id_ex_bubble = w_id_ex_bubble;
    assign hz.pipe_en      = w_pipe_en;
    assign hz.halted       = halted_q;
    assign hz.stall_count  = stall_count_q;

endmodule : hazard_controller

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// Module      : tb_hazard_controller
// Description : Directed scoreboard bench for hazard_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_controller;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_en, halted}
    localparam logic [5:0] E_NORM = 6'b110010;
    localparam logic [5:0] E_ZERO = 6'b000000;
    localparam logic [5:0] E_LU   = 6'b000110;
    localparam logic [5:0] E_BR   = 6'b111010;
    localparam logic [5:0] E_DRN  = 6'b011010;
    localparam logic [5:0] E_HLT  = 6'b000001;

    typedef struct packed {
        logic [5:0]  ctl;
        logic [15:0] sc;
    } exp_t;

    logic clk;
    logic rst_n;

    hazard_controller_if hzi ();

    hazard_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hzi.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_total = 0;
    int    n_pass  = 0;

    // Monitor: every negedge, compare against the expectation queued this cycle
    always @(negedge clk) begin
        exp_t       e;
        exp_t       a;
        string      nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a.ctl = {hzi.pc_write, hzi.if_id_write, hzi.if_id_flush,
                     hzi.id_ex_bubble, hzi.pipe_en, hzi.halted};
            a.sc  = hzi.stall_count;
            n_total++;
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got ctl=%b sc=%h, required ctl=%b sc=%h",
                         nm, a.ctl, a.sc, e.ctl, e.sc);
            end
        end
    end

    task automatic drive(input logic rst, input logic [3:0] s1, input logic [3:0] s2,
                         input logic u2, input logic [3:0] dst, input logic mr,
                         input logic br, input logic hlt, input logic ms);
        @(posedge clk);
        #1;
        rst_n             = rst;
        hzi.id_srcReg1    = s1;
        hzi.id_srcReg2    = s2;
        hzi.id_usesSrc2   = u2;
        hzi.id_ex_dstReg  = dst;
        hzi.id_ex_memRead = mr;
        hzi.branch_taken  = br;
        hzi.id_halt       = hlt;
        hzi.mem_stall_req = ms;
    endtask

    task automatic step(input logic rst, input logic [3:0] s1, input logic [3:0] s2,
                        input logic u2, input logic [3:0] dst, input logic mr,
                        input logic br, input logic hlt, input logic ms,
                        input logic [5:0] ctl, input logic [15:0] sc, input string nm);
        exp_t e;
        drive(rst, s1, s2, u2, dst, mr, br, hlt, ms);
        e.ctl = ctl;
        e.sc  = sc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        rst_n             = 1'b0;
        hzi.id_srcReg1    = '0;
        hzi.id_srcReg2    = '0;
        hzi.id_usesSrc2   = 1'b0;
        hzi.id_ex_dstReg  = '0;
        hzi.id_ex_memRead = 1'b0;
        hzi.branch_taken  = 1'b0;
        hzi.id_halt       = 1'b0;
        hzi.mem_stall_req = 1'b0;

        //   rst s1 s2 u2 dst mr br hl ms  ctl     sc
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd0,  "reset_state");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd0,  "first_run");
        step(1, 5, 0, 0, 5, 1, 0, 0, 0, E_LU,   16'd0,  "load_use_src1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd1,  "after_load_use");
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, E_NORM, 16'd1,  "r0_no_stall");
        step(1, 1, 7, 0, 7, 1, 0, 0, 0, E_NORM, 16'd1,  "src2_unused");
        step(1, 1, 7, 1, 7, 1, 0, 0, 0, E_LU,   16'd1,  "src2_used");
        step(1, 3, 0, 0, 3, 1, 1, 0, 0, E_LU,   16'd2,  "load_use_over_branch");
        step(1, 3, 0, 0, 0, 0, 1, 0, 0, E_BR,   16'd3,  "branch_retry");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 16'd3,  "mem_stall_1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 16'd4,  "mem_stall_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 16'd5,  "mem_stall_3");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 16'd6,  "mem_stall_4");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd7,  "mem_wait_exit");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd7,  "run_after_wait");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, E_DRN,  16'd7,  "halt_issue");
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, E_DRN,  16'd8,  "drain_3");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 16'd9,  "drain_stall_1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 16'd10, "drain_stall_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_DRN,  16'd11, "drain_resume");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_DRN,  16'd12, "drain_last");
        step(1, 0, 0, 0, 0, 0, 1, 1, 1, E_HLT,  16'd13, "halted_ignores");
        step(1, 5, 0, 0, 5, 1, 1, 0, 0, E_HLT,  16'd13, "halted_hold");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd0,  "reset_from_halt");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd0,  "run_again");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, E_DRN,  16'd0,  "halt_issue_2");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_DRN,  16'd1,  "drain_before_reset");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd0,  "reset_mid_drain");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd0,  "run_after_reset");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'd0,  "run_steady");

        // Long memory stall to push the counter into saturation
        for (int i = 0; i < 65536; i++) begin
            drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 16'hFFFF, "stall_saturated");
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, E_ZERO, 16'hFFFF, "stall_no_wrap");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, E_NORM, 16'hFFFF, "sat_wait_exit");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_hazard_controller

`default_nettype wire

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports declared as follows.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-002 The block SHALL have these inputs:
- id_srcReg1  in  4  ID-stage source register 1.
- id_srcReg2  in  4  ID-stage source register 2.
- id_usesSrc2  in  1  ID instruction reads srcReg2.
- id_ex_dstReg  in  4  EX-stage destination register.
- id_ex_memRead  in  1  EX-stage instruction is a load.
- branch_taken  in  1  branch resolved taken in ID this cycle.
- id_halt  in  1  ID instruction is HLT.
- mem_stall_req  in  1  I-cache or D-cache miss outstanding; level signal.
REQ-003 The block SHALL have these outputs:
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID register loads a NOP.
- id_ex_bubble  out  1  ID/EX register loads a NOP.
- pipe_en  out  1  ID/EX, EX/MEM and MEM/WB register enable.
- halted  out  1  processor stopped.
- stall_count  out  16  saturating count of cycles with pc_write=0.

Function
REQ-004 The FSM SHALL have states RUN, MEM_WAIT, DRAIN and HALTED; a 1-bit resume register SHALL record RUN or DRAIN for MEM_WAIT exit.
REQ-005 Load-use SHALL be detected combinationally as:
- id_ex_memRead=1 and id_ex_dstReg!=0; and
- id_ex_dstReg==id_srcReg1, or (id_usesSrc2 and id_ex_dstReg==id_srcReg2).
REQ-006 In RUN, the highest-priority matching action SHALL apply:
- mem_stall_req=1 -> pc_write=0, if_id_write=0, pipe_en=0; next state MEM_WAIT, resume=RUN.
- load-use -> pc_write=0, if_id_write=0, id_ex_bubble=1, pipe_en=1; exactly one bubble per hazard; branch_taken is ignored that cycle.
- branch_taken -> if_id_flush=1, pc_write=1.
- id_halt -> pc_write=0, if_id_flush=1; next state DRAIN, drain counter loaded with 3.
- otherwise -> pc_write=1, if_id_write=1, pipe_en=1, flush and bubble outputs 0.
REQ-007 In MEM_WAIT, pc_write, if_id_write and pipe_en SHALL be 0; when mem_stall_req=0 the next state SHALL be the resume state, and outputs SHALL already be normal in that exit cycle.
REQ-008 In DRAIN:
- pc_write=0, if_id_flush=1, pipe_en=1.
- The counter SHALL decrement each cycle.
- When the counter reads 1 and decrements, the next state SHALL be HALTED.
- mem_stall_req=1 SHALL go to MEM_WAIT with resume=DRAIN, holding the counter.
REQ-009 In HALTED:
- halted=1 and pc_write=0, if_id_write=0, pipe_en=0.
- All inputs SHALL be ignored.
- Only reset SHALL exit this state.
REQ-010 stall_count SHALL increment every cycle pc_write=0 and halted=0, and SHALL saturate at 0xFFFF without wrapping.
REQ-011 All outputs except stall_count and halted SHALL be combinational decodes of the current state and inputs; stall_count and halted SHALL be registered.

Reset
REQ-012 While rst_n=0:
- state=RUN, resume=RUN, drain counter=0, stall_count=0, halted=0.
- Assertion mid-MEM_WAIT or mid-DRAIN SHALL abandon that operation immediately.
REQ-013 In the first cycle after deassertion the block SHALL behave as RUN, so pc_write=1 when no hazard input is active.

Structure
REQ-014 A shared package SHALL hold the state enumeration, DRAIN_CYCLES=3, REG_ZERO=4'h0 and the 16-bit counter width.
REQ-015 Load-use comparison SHALL be a separate combinational sub-module, load_use_detect; the FSM, counters and output decode SHALL remain in hazard_controller.

Verification
REQ-016 Load-use: id_ex_memRead=1, id_ex_dstReg=5, id_srcReg1=5 for one cycle -> that cycle pc_write=0, id_ex_bubble=1; next cycle pc_write=1; stall_count=1.
REQ-017 R0 and unused src2:
- id_ex_dstReg=0 with a load -> no stall.
- id_srcReg2 match with id_usesSrc2=0 -> no stall.
REQ-018 Load-use with branch_taken=1 in the same cycle -> id_ex_bubble=1, if_id_flush=0; the branch flush takes effect only on the retried cycle.
REQ-019 mem_stall_req=1 for 4 cycles in RUN -> pipe_en=0 for 4 cycles, return to RUN, stall_count=4.
REQ-020 id_halt, then mem_stall_req for 2 cycles during DRAIN -> HALTED reached after 3 DRAIN cycles plus 2 wait cycles; halted=1 thereafter; branch_taken ignored.
REQ-021 rst_n low for 1 cycle during DRAIN -> state RUN, halted=0, stall_count=0, pc_write=1 the next cycle.
